trace_checker: RTL and testbench
================================

Name: trace_checker

Overview:
- Receiving end of the processor trace interface (valid / instruction / result), used in place of a passive display consumer.
- Buffers each trace beat in a small FIFO.
- Checks every beat in a 2-stage pipeline:
  - result must equal instruction XOR key;
  - instructions must form a contiguous incrementing sequence.
- Keeps saturating pass/error/sequence/overflow counters and captures the first failing beat for the testbench or a status register.

Parameters:
- WIDTH, 16, width of instruction and result.
- XOR_KEY, 16'h00FF, expected transform: result == instruction ^ XOR_KEY (WIDTH bits).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled only on rising clk.
- in_valid  in  1  trace beat present this cycle; no backpressure exists.
- in_instruction  in  WIDTH  traced instruction.
- in_result  in  WIDTH  traced result.
- chk_enable  in  1  1 = checker may pop the FIFO; 0 = stall (FIFO may fill).
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- pass_count  out  16  beats passing both checks; saturating.
- err_count  out  16  beats failing the result check; saturating.
- seq_err_count  out  16  beats failing the sequence check; saturating.
- overflow_count  out  16  beats dropped because the FIFO was full; saturating.
- first_err_valid  out  1  a result error has been captured.
- first_err_instruction  out  WIDTH  instruction of the first result error.
- first_err_result  out  WIDTH  result of the first result error.
- busy  out  1  FIFO non-empty or check stage holds a beat.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs, FIFO pointers and stage registers go to 0; sequence FSM goes to FIRST. Reset wins over every simultaneous event. Beats in flight are discarded.
- FIFO push: at an edge with in_valid==1, the beat is written if FIFO not full, or if full and a pop occurs on the same edge.
- FIFO overflow: otherwise the beat is dropped and overflow_count increments.
- FIFO pop: at an edge with chk_enable==1 and FIFO non-empty, the head moves into stage register S1 (s1_valid=1). Otherwise s1_valid=0.
- Push into an empty FIFO is not popped on the same edge (no bypass).
- Check stage: at the edge after S1 loads, counters and FSM update from S1.
- Latency: a beat sampled at edge k, with chk_enable high and FIFO empty, updates counters at edge k+2. Sustained throughput is 1 beat/cycle.
- Result check: res_ok = (S1.result == S1.instruction ^ XOR_KEY).
- Sequence FSM, 2 states, FIRST and TRACK; expected register is WIDTH bits:
  - FIRST: any beat is seq_ok; expected <= instruction+1; go to TRACK.
  - TRACK: seq_ok = (instruction == expected). Always expected <= instruction+1 (resync on mismatch).
- Wrap-around: expected wraps modulo 2^WIDTH, so 0xFFFF followed by 0x0000 is seq_ok.
- Counter updates per checked beat:
  - res_ok && seq_ok: pass_count+1.
  - !res_ok: err_count+1.
  - !seq_ok: seq_err_count+1.
  - A beat failing both checks increments both error counters; pass_count is unchanged.
- Saturation: every counter holds at 0xFFFF.
- First-error capture: on the first !res_ok beat since reset, load first_err_* and set first_err_valid. The capture is frozen until reset.
- Simultaneous overflow and check events on one edge update their respective counters independently.
- fifo_level and busy are registered-state decodes, valid in the cycle after each edge.

Test Plan:
- Clean stream: in_valid=1 for 100 cycles, instruction 0..99, result=i^0x00FF, chk_enable=1 → pass_count=100; err/seq_err/overflow=0; pass_count first reads 1 two edges after the first sample.
- Result corruption: instruction 5 with result 0x0000 (expected 0x00FA), instruction 9 with result 0x1234 → err_count=2, first_err_instruction=5, first_err_result=0x0000, first_err_valid=1, pass_count=98 of 100.
- Sequence gap: send 0..9, then 11..20 → seq_err_count=1 (on 11), no further seq errors, pass_count=19.
- Overflow: chk_enable=0, DEPTH=4, 6 back-to-back beats 0..5 → fifo_level=4, overflow_count=2. Then chk_enable=1 and send 6 → pass_count=4 after drain, beat 6 gives seq_err_count=1.
- Wrap: instructions 0xFFFE, 0xFFFF, 0x0000, 0x0001 with correct results → pass_count=4, seq_err_count=0.
- Mid-stream reset: stall with 3 entries queued, counters non-zero, drive reset=0 for 1 edge → all outputs 0 next cycle. Then a restart at instruction 0x0040 gives pass_count=1, seq_err_count=0.

Source files
------------

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - trace receiver: beat FIFO, result/sequence checker, saturating counters
//   clk, reset (sync, active-low)
//   in_valid / in_instruction / in_result : trace beats, no backpressure
//   chk_enable                            : 1 lets the checker pop the FIFO
//   fifo_level, busy                      : occupancy and activity status
//   pass/err/seq_err/overflow_count       : saturating 16-bit counters
//   first_err_*                           : frozen capture of the first result error
module trace_checker #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] XOR_KEY = 'h00FF,
  parameter int               DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_instruction,
  input  logic [WIDTH-1:0]           in_result,
  input  logic                       chk_enable,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                pass_count,
  output logic [15:0]                err_count,
  output logic [15:0]                seq_err_count,
  output logic [15:0]                overflow_count,
  output logic                       first_err_valid,
  output logic [WIDTH-1:0]           first_err_instruction,
  output logic [WIDTH-1:0]           first_err_result,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    FIRST = 1'b0,
    TRACK = 1'b1
  } seq_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // FIFO entries hold {instruction, result}
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] mem_d [DEPTH];
  // One extra pointer bit distinguishes full from empty
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_instr_q, s1_instr_d;
  logic [WIDTH-1:0]   s1_res_q, s1_res_d;

  seq_state_e         state_q, state_d;
  logic [WIDTH-1:0]   expected_q, expected_d;

  logic [15:0]        pass_q, pass_d;
  logic [15:0]        err_q, err_d;
  logic [15:0]        seq_err_q, seq_err_d;
  logic [15:0]        ovf_q, ovf_d;
  logic               ferr_valid_q, ferr_valid_d;
  logic [WIDTH-1:0]   ferr_instr_q, ferr_instr_d;
  logic [WIDTH-1:0]   ferr_res_q, ferr_res_d;

  logic [AW:0]        level;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               res_ok;
  logic               seq_ok;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(DEPTH));

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    s1_valid_d   = 1'b0;
    s1_instr_d   = s1_instr_q;
    s1_res_d     = s1_res_q;
    state_d      = state_q;
    expected_d   = expected_q;
    pass_d       = pass_q;
    err_d        = err_q;
    seq_err_d    = seq_err_q;
    ovf_d        = ovf_q;
    ferr_valid_d = ferr_valid_q;
    ferr_instr_d = ferr_instr_q;
    ferr_res_d   = ferr_res_q;

    // Pop decision uses pre-edge occupancy, so a beat pushed into an
    // empty FIFO is never popped on the same edge.
    pop  = chk_enable && !fifo_empty;
    // A full FIFO still accepts a beat when the head leaves on this edge.
    push = in_valid && (!fifo_full || pop);

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {in_instruction, in_result};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (in_valid) begin
      ovf_d = sat_inc(ovf_q);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      s1_valid_d = 1'b1;
      {s1_instr_d, s1_res_d} = mem_q[rd_ptr_q[AW-1:0]];
    end

    res_ok = (s1_res_q == (s1_instr_q ^ XOR_KEY));
    seq_ok = (state_q == FIRST) || (s1_instr_q == expected_q);

    if (s1_valid_q) begin
      // Always resynchronise to the observed instruction
      state_d    = TRACK;
      expected_d = s1_instr_q + WIDTH'(1);
      if (res_ok && seq_ok) pass_d    = sat_inc(pass_q);
      if (!res_ok)          err_d     = sat_inc(err_q);
      if (!seq_ok)          seq_err_d = sat_inc(seq_err_q);
      if (!res_ok && !ferr_valid_q) begin
        ferr_valid_d = 1'b1;
        ferr_instr_d = s1_instr_q;
        ferr_res_d   = s1_res_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_instr_q   <= '0;
      s1_res_q     <= '0;
      state_q      <= FIRST;
      expected_q   <= '0;
      pass_q       <= '0;
      err_q        <= '0;
      seq_err_q    <= '0;
      ovf_q        <= '0;
      ferr_valid_q <= 1'b0;
      ferr_instr_q <= '0;
      ferr_res_q   <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_instr_q   <= s1_instr_d;
      s1_res_q     <= s1_res_d;
      state_q      <= state_d;
      expected_q   <= expected_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      seq_err_q    <= seq_err_d;
      ovf_q        <= ovf_d;
      ferr_valid_q <= ferr_valid_d;
      ferr_instr_q <= ferr_instr_d;
      ferr_res_q   <= ferr_res_d;
    end
  end

  assign fifo_level            = level;
  assign busy                  = !fifo_empty || s1_valid_q;
  assign pass_count            = pass_q;
  assign err_count             = err_q;
  assign seq_err_count         = seq_err_q;
  assign overflow_count        = ovf_q;
  assign first_err_valid       = ferr_valid_q;
  assign first_err_instruction = ferr_instr_q;
  assign first_err_result      = ferr_res_q;

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed table and sequence bench for trace_checker
module tb_trace_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_instruction;
  logic [15:0] in_result;
  logic        chk_enable;
  logic [2:0]  fifo_level;
  logic [15:0] pass_count;
  logic [15:0] err_count;
  logic [15:0] seq_err_count;
  logic [15:0] overflow_count;
  logic        first_err_valid;
  logic [15:0] first_err_instruction;
  logic [15:0] first_err_result;
  logic        busy;

  int tests = 0;
  int fails = 0;

  trace_checker #(.WIDTH(16), .XOR_KEY(16'h00FF), .DEPTH(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_valid              (in_valid),
    .in_instruction        (in_instruction),
    .in_result             (in_result),
    .chk_enable            (chk_enable),
    .fifo_level            (fifo_level),
    .pass_count            (pass_count),
    .err_count             (err_count),
    .seq_err_count         (seq_err_count),
    .overflow_count        (overflow_count),
    .first_err_valid       (first_err_valid),
    .first_err_instruction (first_err_instruction),
    .first_err_result      (first_err_result),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] res;
    logic        chk;
    int          level;
    int          pass;
    int          err;
    int          seq;
    int          ovf;
    int          busy;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] instr, input logic [15:0] res);
    in_valid       = 1'b1;
    in_instruction = instr;
    in_result      = res;
    tick();
    in_valid       = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    reset    = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_instruction = '0;
    in_result      = '0;
    chk_enable     = 1'b1;

    //           rst valid instr     res       chk  lvl pass err seq ovf busy
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 16'h0000, 16'h00FF, 1'b1, 1, 0, 0, 0, 0, 1};
    vecs[2]  = '{1'b1, 1'b1, 16'h0001, 16'h00FE, 1'b1, 1, 0, 0, 0, 0, 1};
    vecs[3]  = '{1'b1, 1'b1, 16'h0002, 16'h00FD, 1'b1, 1, 1, 0, 0, 0, 1};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 2, 0, 0, 0, 1};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 3, 0, 0, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 16'h0004, 16'h00FB, 1'b1, 1, 3, 0, 0, 0, 1};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 3, 0, 0, 0, 1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 3, 0, 1, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 16'h0005, 16'h0000, 1'b1, 1, 3, 0, 1, 0, 1};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 3, 0, 1, 0, 1};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 3, 1, 1, 0, 0};
    vecs[12] = '{1'b1, 1'b1, 16'h0006, 16'h00F9, 1'b0, 1, 3, 1, 1, 0, 1};
    vecs[13] = '{1'b1, 1'b1, 16'h0007, 16'h00F8, 1'b0, 2, 3, 1, 1, 0, 1};
    vecs[14] = '{1'b1, 1'b1, 16'h0008, 16'h00F7, 1'b0, 3, 3, 1, 1, 0, 1};
    vecs[15] = '{1'b1, 1'b1, 16'h0009, 16'h00F6, 1'b0, 4, 3, 1, 1, 0, 1};
    vecs[16] = '{1'b1, 1'b1, 16'h000A, 16'h00F5, 1'b0, 4, 3, 1, 1, 1, 1};
    vecs[17] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 4, 3, 1, 1, 1, 1};

    for (int i = 0; i < 18; i++) begin
      reset          = vecs[i].rst_n;
      in_valid       = vecs[i].valid;
      in_instruction = vecs[i].instr;
      in_result      = vecs[i].res;
      chk_enable     = vecs[i].chk;
      tick();
      check($sformatf("v%0d.level", i), int'(fifo_level),     vecs[i].level);
      check($sformatf("v%0d.pass", i),  int'(pass_count),     vecs[i].pass);
      check($sformatf("v%0d.err", i),   int'(err_count),      vecs[i].err);
      check($sformatf("v%0d.seq", i),   int'(seq_err_count),  vecs[i].seq);
      check($sformatf("v%0d.ovf", i),   int'(overflow_count), vecs[i].ovf);
      check($sformatf("v%0d.busy", i),  int'(busy),           vecs[i].busy);
    end
    check("table.ferr_valid", int'(first_err_valid),       1);
    check("table.ferr_instr", int'(first_err_instruction), 16'h0005);
    check("table.ferr_res",   int'(first_err_result),      16'h0000);

    // Clean stream with latency probe on the first beats
    chk_enable = 1'b1;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      send_beat(16'(i), 16'(i) ^ 16'h00FF);
      if (i == 0) check("clean.lat0", int'(pass_count), 0);
      if (i == 1) check("clean.lat1", int'(pass_count), 0);
      if (i == 2) check("clean.lat2", int'(pass_count), 1);
    end
    idle(4);
    check("clean.pass", int'(pass_count),      100);
    check("clean.err",  int'(err_count),       0);
    check("clean.seq",  int'(seq_err_count),   0);
    check("clean.ovf",  int'(overflow_count),  0);
    check("clean.ferr", int'(first_err_valid), 0);
    check("clean.busy", int'(busy),            0);

    // Result corruption on 5 and 9
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (i == 5)      send_beat(16'(i), 16'h0000);
      else if (i == 9) send_beat(16'(i), 16'h1234);
      else             send_beat(16'(i), 16'(i) ^ 16'h00FF);
    end
    idle(4);
    check("corrupt.err",        int'(err_count),             2);
    check("corrupt.pass",       int'(pass_count),            98);
    check("corrupt.seq",        int'(seq_err_count),         0);
    check("corrupt.ferr_valid", int'(first_err_valid),       1);
    check("corrupt.ferr_instr", int'(first_err_instruction), 5);
    check("corrupt.ferr_res",   int'(first_err_result),      0);

    // Sequence gap: 0..9 then 11..20
    do_reset();
    for (int i = 0; i < 21; i++)
      if (i != 10) send_beat(16'(i), 16'(i) ^ 16'h00FF);
    idle(4);
    check("gap.seq",  int'(seq_err_count), 1);
    check("gap.pass", int'(pass_count),    19);
    check("gap.err",  int'(err_count),     0);

    // Overflow while stalled, then full-and-pop push on resume
    do_reset();
    chk_enable = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(16'(i), 16'(i) ^ 16'h00FF);
    check("ovf.level", int'(fifo_level),     4);
    check("ovf.count", int'(overflow_count), 2);
    check("ovf.pass0", int'(pass_count),     0);
    chk_enable = 1'b1;
    send_beat(16'h0006, 16'h0006 ^ 16'h00FF);
    check("ovf.level_after_pop", int'(fifo_level), 4);
    idle(8);
    check("ovf.pass",  int'(pass_count),     4);
    check("ovf.seq",   int'(seq_err_count),  1);
    check("ovf.count_after", int'(overflow_count), 2);
    check("ovf.level_drained", int'(fifo_level), 0);

    // Wrap-around of the expected instruction
    do_reset();
    send_beat(16'hFFFE, 16'hFFFE ^ 16'h00FF);
    send_beat(16'hFFFF, 16'hFFFF ^ 16'h00FF);
    send_beat(16'h0000, 16'h00FF);
    send_beat(16'h0001, 16'h00FE);
    idle(4);
    check("wrap.pass", int'(pass_count),    4);
    check("wrap.seq",  int'(seq_err_count), 0);

    // Mid-stream reset with beats queued and a beat arriving on the reset edge
    do_reset();
    send_beat(16'h0000, 16'h0000);
    idle(3);
    check("mid.err_pre", int'(err_count), 1);
    chk_enable = 1'b0;
    send_beat(16'h0001, 16'h00FE);
    send_beat(16'h0002, 16'h00FD);
    send_beat(16'h0003, 16'h00FC);
    check("mid.level_pre", int'(fifo_level), 3);
    reset          = 1'b0;
    in_valid       = 1'b1;
    in_instruction = 16'h0004;
    in_result      = 16'h00FB;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    check("mid.level",      int'(fifo_level),            0);
    check("mid.pass",       int'(pass_count),            0);
    check("mid.err",        int'(err_count),             0);
    check("mid.seq",        int'(seq_err_count),         0);
    check("mid.ovf",        int'(overflow_count),        0);
    check("mid.ferr_valid", int'(first_err_valid),       0);
    check("mid.ferr_instr", int'(first_err_instruction), 0);
    check("mid.ferr_res",   int'(first_err_result),      0);
    check("mid.busy",       int'(busy),                  0);
    chk_enable = 1'b1;
    send_beat(16'h0040, 16'h0040 ^ 16'h00FF);
    idle(4);
    check("restart.pass", int'(pass_count),    1);
    check("restart.seq",  int'(seq_err_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
